cmp_search_ctrl: RTL



---
 rtl/cmp_search_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for an external combinational magnitude comparator.
// Drives guess onto the comparator B input and narrows [lo, hi] from the gt/eq/lt flags.
module cmp_search_ctrl #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_great_b,
  input  logic         a_equal_b,
  input  logic         a_less_b,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] found,
  output logic         err,
  output logic [7:0]   probes
);

  typedef enum logic {IDLE, PROBE} state_t;

  localparam logic [W:0] HI_INIT = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ONE_EXT = {{W{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [W:0]   lo_q, lo_d, hi_q, hi_d;
  logic [W-1:0] guess_q, guess_d, found_q, found_d;
  logic         done_q, done_d, err_q, err_d;
  logic [7:0]   probes_q, probes_d;

  logic [W:0]   guess_ext, lo_nxt, hi_nxt;
  logic [1:0]   flag_cnt;

  // Midpoint taken at W+1 bits so lo+hi never overflows, then truncated to W.
  function automatic logic [W-1:0] midpoint(input logic [W:0] l, input logic [W:0] h);
    logic [W:0] s;
    s = l + h;
    return s[W:1];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] p);
    return (p == 8'hFF) ? p : p + 8'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    guess_d   = guess_q;
    found_d   = found_q;
    err_d     = err_q;
    probes_d  = probes_q;
    done_d    = 1'b0;
    guess_ext = {1'b0, guess_q};
    lo_nxt    = guess_ext + ONE_EXT;
    hi_nxt    = guess_ext - ONE_EXT;
    flag_cnt  = {1'b0, a_great_b} + {1'b0, a_equal_b} + {1'b0, a_less_b};

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = HI_INIT;
          guess_d  = midpoint('0, HI_INIT);
          probes_d = '0;
          found_d  = '0;
          err_d    = 1'b0;
          state_d  = PROBE;
        end
      end
      PROBE: begin
        probes_d = sat_inc(probes_q);
        // Every terminating branch latches the current guess and returns guess to 0.
        if (flag_cnt != 2'd1) begin
          err_d = 1'b1;
          done_d = 1'b1;
        end else if (a_equal_b) begin
          err_d = 1'b0;
          done_d = 1'b1;
        end else if (a_great_b) begin
          if (guess_ext == hi_q) begin
            err_d = 1'b1;
            done_d = 1'b1;
          end else begin
            lo_d    = lo_nxt;
            guess_d = midpoint(lo_nxt, hi_q);
          end
        end else begin
          if (guess_ext == lo_q) begin
            err_d = 1'b1;
            done_d = 1'b1;
          end else begin
            hi_d    = hi_nxt;
            guess_d = midpoint(lo_q, hi_nxt);
          end
        end
        if (done_d) begin
          found_d = guess_q;
          guess_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      found_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      done_q   <= done_d;
      err_q    <= err_d;
      probes_q <= probes_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == PROBE);
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign probes = probes_q;

endmodule
